// File: rtl/encoder32to5_queue_pkg.sv
// Shared widths and state encoding for the select encoder/decoder pair.
package encoder32to5_queue_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned SEL_WIDTH = 5;
  localparam int unsigned CNT_WIDTH = SEL_WIDTH + 1;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/encoder32to5_queue_if.sv
// Request/offer bundle between the encoder queue and its producer/consumer.
interface encoder32to5_queue_if;
  import encoder32to5_queue_pkg::*;

  logic                 enable;
  logic [WIDTH-1:0]     req_in;
  logic                 req_load;
  logic                 out_ready;
  logic                 out_valid;
  logic [SEL_WIDTH-1:0] out_index;
  logic [WIDTH-1:0]     pending;
  logic [CNT_WIDTH-1:0] pending_count;

  // Queue side: takes requests, makes offers.
  modport master (
    input  enable, req_in, req_load, out_ready,
    output out_valid, out_index, pending, pending_count
  );

  // Environment side: supplies requests, consumes offers.
  modport slave (
    output enable, req_in, req_load, out_ready,
    input  out_valid, out_index, pending, pending_count
  );

endinterface

// File: rtl/encoder32to5_queue_prio_enc32.sv
// Combinational lowest-set-bit finder: idx is the smallest set position.
module encoder32to5_queue_prio_enc32
  import encoder32to5_queue_pkg::*;
(
  input  logic [WIDTH-1:0]     vec,
  output logic [SEL_WIDTH-1:0] idx,
  output logic                 any
);

  // Scan high to low so the last hit (lowest index) wins.
  always_comb begin
    idx = '0;
    any = |vec;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = SEL_WIDTH'(i);
    end
  end

endmodule

// File: rtl/encoder32to5_queue.sv
// Collects multi-hot request lines and offers them one index at a time,
// lowest index first, on a valid/ready handshake.
module encoder32to5_queue
  import encoder32to5_queue_pkg::*;
(
  input  logic                        clock,
  input  logic                        reset,
  encoder32to5_queue_if.master        bus
);

  state_t               state_q;
  logic [SEL_WIDTH-1:0] out_index_q;
  logic [WIDTH-1:0]     pending_q;
  logic [CNT_WIDTH-1:0] count_q;

  logic                 accept_c;
  logic [WIDTH-1:0]     clear_mask_c;
  logic [WIDTH-1:0]     pending_next_c;
  logic [CNT_WIDTH-1:0] count_next_c;
  logic [SEL_WIDTH-1:0] low_idx_c;
  logic                 any_c;

  // Lowest pending request, taken from the current register (not pending_next).
  encoder32to5_queue_prio_enc32 u_prio (
    .vec (pending_q),
    .idx (low_idx_c),
    .any (any_c)
  );

  // Pending update: clear the accepted line, then OR in loads (set dominates).
  always_comb begin
    accept_c       = (state_q == ST_PRESENT) && bus.out_ready;
    clear_mask_c   = accept_c ? (WIDTH'(1) << out_index_q) : '0;
    pending_next_c = (pending_q & ~clear_mask_c) | (bus.req_load ? bus.req_in : '0);
  end

  // Population count of the next pending vector so count tracks pending.
  always_comb begin
    count_next_c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count_next_c = count_next_c + CNT_WIDTH'(pending_next_c[i]);
    end
  end

  // Offer state machine and pending register; index held for the whole offer.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      out_index_q <= '0;
      pending_q   <= '0;
      count_q     <= '0;
    end else begin
      pending_q <= pending_next_c;
      count_q   <= count_next_c;
      case (state_q)
        ST_IDLE: begin
          if (bus.enable && any_c) begin
            state_q     <= ST_PRESENT;
            out_index_q <= low_idx_c;
          end
        end
        ST_PRESENT: begin
          if (bus.out_ready) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.out_valid     = (state_q == ST_PRESENT);
  assign bus.out_index     = out_index_q;
  assign bus.pending       = pending_q;
  assign bus.pending_count = count_q;

endmodule

// File: tb/tb_encoder32to5_queue.sv
// Bench for encoder32to5_queue: directed scenarios with literal expectations
// plus a randomized phase, all compared every cycle against a set-based model.
module tb_encoder32to5_queue;

  logic clock;
  logic reset;

  encoder32to5_queue_if bus ();

  encoder32to5_queue dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  int tests  = 0;
  int fails  = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural model: pending set, current offer flag and index.
  logic [31:0] m_pend;
  bit          m_valid;
  int          m_idx;

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return 0;
  endfunction

  always @(posedge clock) begin
    logic [31:0] nxt;
    bit          acc;
    if (reset) begin
      m_pend  = '0;
      m_valid = 1'b0;
      m_idx   = 0;
    end else begin
      acc = m_valid && bus.out_ready;
      nxt = m_pend;
      if (acc) nxt[m_idx] = 1'b0;
      if (bus.req_load) nxt = nxt | bus.req_in;
      if (!m_valid) begin
        if (bus.enable && m_pend != 0) begin
          m_idx   = lowest(m_pend);
          m_valid = 1'b1;
        end
      end else if (acc) begin
        m_valid = 1'b0;
      end
      m_pend = nxt;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      check("m_valid", 32'(bus.out_valid), 32'(m_valid));
      if (m_valid) check("m_index", 32'(bus.out_index), 32'(m_idx));
      check("m_pending", bus.pending, m_pend);
      check("m_count", 32'(bus.pending_count), 32'($countones(m_pend)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic load(input logic [31:0] v);
    bus.req_in   = v;
    bus.req_load = 1'b1;
    step(1);
    bus.req_load = 1'b0;
    bus.req_in   = '0;
  endtask

  int got_q[$];

  initial begin
    bus.enable    = 1'b0;
    bus.out_ready = 1'b0;
    bus.req_in    = 32'hFFFF_FFFF;
    bus.req_load  = 1'b1;
    reset         = 1'b1;
    step(2);
    reset        = 1'b0;
    bus.req_load = 1'b0;
    bus.req_in   = '0;
    check("rst_pending", bus.pending, 32'h0);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_index", 32'(bus.out_index), 32'h0);
    check("rst_count", 32'(bus.pending_count), 32'h0);
    chk_en = 1'b1;

    // Single request, accepted immediately.
    bus.enable    = 1'b1;
    bus.out_ready = 1'b1;
    load(32'h0000_0020);
    check("single_pend", bus.pending, 32'h20);
    check("single_cnt1", 32'(bus.pending_count), 32'd1);
    check("single_valid0", 32'(bus.out_valid), 32'h0);
    step(1);
    check("single_valid", 32'(bus.out_valid), 32'h1);
    check("single_index", 32'(bus.out_index), 32'd5);
    step(1);
    check("single_cleared", 32'(bus.out_valid), 32'h0);
    check("single_cnt0", 32'(bus.pending_count), 32'd0);

    // Priority and hold while a higher-priority request arrives.
    bus.out_ready = 1'b0;
    load(32'h8000_0004);
    step(1);
    check("prio_index2", 32'(bus.out_index), 32'd2);
    load(32'h0000_0001);
    check("hold_index2", 32'(bus.out_index), 32'd2);
    check("hold_pend", bus.pending, 32'h8000_0005);
    bus.out_ready = 1'b1;
    step(2);
    check("prio_index0", 32'(bus.out_index), 32'd0);
    step(2);
    check("prio_index31", 32'(bus.out_index), 32'd31);
    step(1);
    check("prio_done", 32'(bus.out_valid), 32'h0);

    // All-ones sweep: offers 0..31 in order, one per two cycles.
    load(32'hFFFF_FFFF);
    check("sweep_cnt32", 32'(bus.pending_count), 32'd32);
    got_q.delete();
    for (int c = 0; c < 100; c++) begin
      if (bus.out_valid) got_q.push_back(int'(bus.out_index));
      if (bus.pending_count == 0 && !bus.out_valid) break;
      step(1);
    end
    check("sweep_len", 32'(got_q.size()), 32'd32);
    for (int i = 0; i < got_q.size() && i < 32; i++) check("sweep_order", 32'(got_q[i]), 32'(i));
    check("sweep_end_valid", 32'(bus.out_valid), 32'h0);

    // Set dominates clear on the same edge.
    bus.out_ready = 1'b0;
    load(32'h0000_0080);
    step(1);
    check("coll_index7", 32'(bus.out_index), 32'd7);
    bus.out_ready = 1'b1;
    load(32'h0000_0080);
    bus.out_ready = 1'b0;
    check("coll_pend", bus.pending, 32'h80);
    check("coll_cnt", 32'(bus.pending_count), 32'd1);
    step(1);
    check("coll_reoffer", 32'(bus.out_index), 32'd7);
    bus.out_ready = 1'b1;
    step(1);
    bus.out_ready = 1'b0;

    // Enable gating, then reset mid-offer.
    bus.enable = 1'b0;
    load(32'h0000_0300);
    step(3);
    check("gate_valid", 32'(bus.out_valid), 32'h0);
    check("gate_cnt", 32'(bus.pending_count), 32'd2);
    bus.enable = 1'b1;
    step(1);
    check("gate_valid1", 32'(bus.out_valid), 32'h1);
    check("gate_index8", 32'(bus.out_index), 32'd8);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
    check("mid_rst_index", 32'(bus.out_index), 32'h0);
    check("mid_rst_pend", bus.pending, 32'h0);
    check("mid_rst_cnt", 32'(bus.pending_count), 32'h0);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 1500; c++) begin
      bus.enable    = ($urandom_range(0, 9) != 0);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      bus.req_load  = ($urandom_range(0, 3) == 0);
      bus.req_in    = $urandom() & $urandom() & $urandom();
      reset         = ($urandom_range(0, 199) == 0);
      step(1);
    end
    reset        = 1'b0;
    bus.req_load = 1'b0;
    step(1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
